morse_key_collector: RTL and testbench

- Upstream stage of the Morse decoder `de`.
- Samples a single on/off key line and classifies each key press as a dot or a dash by how long it lasts.
- Packs up to 4 elements into the `{morse_in, num}` format that `de` consumes, and presents each completed letter with a 1-cycle valid pulse once the inter-letter gap has elapsed.

---
 rtl/morse_key_collector.sv | 160 ++++++++++++++++
 tb/tb_morse_key_collector.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/morse_key_collector.sv
// rtl/morse_key_collector.sv - classifies key presses as dots/dashes and packs letters for the decoder
// Optional MORSE_DEBOUNCE_EN adds a 2-flop synchroniser and debouncer ahead of the timing logic.
module morse_key_collector #(
  parameter int CNT_W      = 8,
  parameter int DOT_MAX    = 4,
  parameter int LETTER_GAP = 12
`ifdef MORSE_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE   = 3
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [3:0] morse_out,
  output logic [2:0] num_out,
  output logic       valid,
  output logic       error
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DOT_LIM = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(LETTER_GAP);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [3:0]       shift_q, shift_d;
  logic [2:0]       elem_cnt_q, elem_cnt_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       morse_q, morse_d;
  logic [2:0]       num_q, num_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             key_s_q;

`ifdef MORSE_DEBOUNCE_EN
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] deb_cnt_q;

  // A new level is accepted only after it has persisted DEBOUNCE consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_cnt_q <= '0;
      key_s_q   <= 1'b0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      if (sync2_q != key_s_q) begin
        if (deb_cnt_q == CNT_W'(DEBOUNCE - 1)) begin
          key_s_q   <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + CNT_ONE;
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) key_s_q <= 1'b0;
    else     key_s_q <= key_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      press_cnt_q <= '0;
      gap_cnt_q   <= '0;
      shift_q     <= '0;
      elem_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      morse_q     <= '0;
      num_q       <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      press_cnt_q <= press_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      shift_q     <= shift_d;
      elem_cnt_q  <= elem_cnt_d;
      ovf_q       <= ovf_d;
      morse_q     <= morse_d;
      num_q       <= num_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    shift_d     = shift_q;
    elem_cnt_d  = elem_cnt_q;
    ovf_d       = ovf_q;
    morse_d     = morse_q;
    num_d       = num_q;
    valid_d     = 1'b0;
    error_d     = error_q;

    case (state_q)
      IDLE: begin
        if (key_s_q) begin
          state_d     = PRESS;
          press_cnt_d = CNT_ONE;
        end
      end
      PRESS: begin
        if (key_s_q) begin
          if (press_cnt_q != CNT_MAX) press_cnt_d = press_cnt_q + CNT_ONE;
        end else begin
          // First element lands in bit 3; anything past the fourth only flags overflow.
          if (elem_cnt_q < 3'd4) begin
            shift_d[2'd3 - elem_cnt_q[1:0]] = (press_cnt_q > DOT_LIM);
            elem_cnt_d = elem_cnt_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
          gap_cnt_d = CNT_ONE;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (key_s_q) begin
          state_d     = PRESS;
          press_cnt_d = CNT_ONE;
        end else begin
          if (gap_cnt_q != CNT_MAX) gap_cnt_d = gap_cnt_q + CNT_ONE;
          if (gap_cnt_d == GAP_LIM) begin
            morse_d    = shift_q;
            num_d      = elem_cnt_q;
            error_d    = ovf_q;
            valid_d    = 1'b1;
            shift_d    = '0;
            elem_cnt_d = '0;
            ovf_d      = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign morse_out = morse_q;
  assign num_out   = num_q;
  assign valid     = valid_q;
  assign error     = error_q;

endmodule

// File: tb/tb_morse_key_collector.sv
// tb/tb_morse_key_collector.sv - scoreboard bench for morse_key_collector
module tb_morse_key_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic [3:0] morse_out;
  logic [2:0] num_out;
  logic       valid;
  logic       error;

  morse_key_collector dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .morse_out(morse_out),
    .num_out  (num_out),
    .valid    (valid),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] m;
    logic [2:0] n;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_exp = 0;
  int   n_valid = 0;
  logic prev_valid = 1'b0;

  task automatic push(input logic [3:0] m, input logic [2:0] n, input logic e);
    exp_t x;
    x.m = m;
    x.n = n;
    x.e = e;
    exp_q.push_back(x);
    n_exp++;
  endtask

  task automatic hold(input logic lvl, input int n);
    key_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && valid) begin
      n_valid++;
      checks++;
      assert (prev_valid === 1'b0) else begin
        errors++;
        $error("FAIL valid_width observed=%b expected=0", prev_valid);
      end
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_valid observed=%b/%0d expected=no pulse", morse_out, num_out);
      end
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        checks++;
        assert (morse_out === x.m) else begin
          errors++;
          $error("FAIL morse_out observed=%b expected=%b", morse_out, x.m);
        end
        checks++;
        assert (num_out === x.n) else begin
          errors++;
          $error("FAIL num_out observed=%0d expected=%0d", num_out, x.n);
        end
        checks++;
        assert (error === x.e) else begin
          errors++;
          $error("FAIL error observed=%b expected=%b", error, x.e);
        end
      end
    end
    prev_valid = valid;
  end

  initial begin
    int lat;
    rst    = 1'b1;
    key_in = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      assert (morse_out === 4'b0000) else begin errors++; $error("FAIL rst_morse observed=%b expected=0000", morse_out); end
      checks++;
      assert (num_out === 3'd0) else begin errors++; $error("FAIL rst_num observed=%0d expected=0", num_out); end
      checks++;
      assert (valid === 1'b0) else begin errors++; $error("FAIL rst_valid observed=%b expected=0", valid); end
      checks++;
      assert (error === 1'b0) else begin errors++; $error("FAIL rst_error observed=%b expected=0", error); end
    end
    rst    = 1'b0;
    key_in = 1'b0;
    hold(0, 20);

    // C: dash dot dash dot
    push(4'b1010, 3'd4, 1'b0);
    hold(1, 8); hold(0, 3); hold(1, 2); hold(0, 3);
    hold(1, 8); hold(0, 3); hold(1, 2); hold(0, 16);

    // Dot/dash boundary
    push(4'b0000, 3'd1, 1'b0);
    hold(1, 4); hold(0, 16);
    push(4'b1000, 3'd1, 1'b0);
    hold(1, 5); hold(0, 16);

    // Gap of 11 keeps the letter together
    push(4'b0000, 3'd2, 1'b0);
    hold(1, 2); hold(0, 11); hold(1, 2); hold(0, 16);

    // Overflow then clean E
    push(4'b0000, 3'd4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      hold(1, 2); hold(0, 3);
    end
    hold(0, 16);
    push(4'b0000, 3'd1, 1'b0);
    hold(1, 2); hold(0, 16);

    // Y: dash dot dash dash, then outputs hold
    push(4'b1011, 3'd4, 1'b0);
    hold(1, 6); hold(0, 3); hold(1, 2); hold(0, 3);
    hold(1, 6); hold(0, 3); hold(1, 6); hold(0, 16);
    hold(0, 5);
    @(negedge clk);
    checks++;
    assert (morse_out === 4'b1011) else begin errors++; $error("FAIL hold_morse observed=%b expected=1011", morse_out); end
    checks++;
    assert (num_out === 3'd4) else begin errors++; $error("FAIL hold_num observed=%0d expected=4", num_out); end
    checks++;
    assert (valid === 1'b0) else begin errors++; $error("FAIL hold_valid observed=%b expected=0", valid); end
    @(posedge clk); #1;

    // Long press saturates the counter and is still a dash
    push(4'b1000, 3'd1, 1'b0);
    hold(1, 300); hold(0, 16);

    // Reset mid-letter discards it
    hold(1, 6); hold(0, 3); hold(1, 6); hold(0, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hold(0, 16);
    push(4'b0000, 3'd1, 1'b0);
    hold(1, 3); hold(0, 16);

    // A: latency from key release to valid
    push(4'b0100, 3'd2, 1'b0);
    hold(1, 2); hold(0, 2); hold(1, 6);
    key_in = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (valid) begin
        lat = i;
        break;
      end
    end
    checks++;
    assert (lat == 14) else begin errors++; $error("FAIL latency observed=%0d expected=14", lat); end
    @(posedge clk); #1;
    hold(0, 5);

    checks++;
    assert (exp_q.size() == 0) else begin errors++; $error("FAIL missing_valid observed=%0d pending expected=0", exp_q.size()); end
    checks++;
    assert (n_valid == n_exp) else begin errors++; $error("FAIL valid_count observed=%0d expected=%0d", n_valid, n_exp); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
